// File: rtl/instr_fetch_decode.sv
// Byte-serial instruction fetch/decode: assembles short (1-byte) and long (2-byte)
// instructions into a registered bundle. Optional illegal-opcode flagging under DECODE_ILLEGAL_EN.
module instr_fetch_decode #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned OPC_W        = 5,
    parameter int unsigned REG_W        = 3,
    parameter int unsigned LONG_OPC_MIN = 16,
    parameter int unsigned NUM_OPC      = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rs,
    output logic [DATA_W-1:0] k,
    output logic              len
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic              illegal,
    output logic [7:0]        illegal_cnt
`endif
);

    localparam logic [1:0] S_OP  = 2'd0;
    localparam logic [1:0] S_ARG = 2'd1;
    localparam logic [1:0] S_OUT = 2'd2;

    if (OPC_W + REG_W != DATA_W) begin : g_chk_fields
        $error("OPC_W + REG_W must equal DATA_W");
    end
    if (NUM_OPC > (1 << OPC_W)) begin : g_chk_num_opc
        $error("NUM_OPC exceeds the opcode space");
    end

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_byte0;
    logic              r_out_valid;
    logic [OPC_W-1:0]  r_opcode;
    logic [REG_W-1:0]  r_rd;
    logic [REG_W-1:0]  r_rs;
    logic [DATA_W-1:0] r_k;
    logic              r_len;
    logic [OPC_W-1:0]  w_opc;
    logic              w_illegal;
    logic              w_long;

    // Illegal opcodes are forced short so they never swallow an operand byte.
    always_comb begin
        w_opc     = in_byte[DATA_W-1 -: OPC_W];
`ifdef DECODE_ILLEGAL_EN
        w_illegal = 32'(w_opc) >= NUM_OPC;
`else
        w_illegal = 1'b0;
`endif
        w_long    = (32'(w_opc) >= LONG_OPC_MIN) && !w_illegal;
    end

    assign in_ready  = (r_state == S_OP) || (r_state == S_ARG);
    assign out_valid = r_out_valid;
    assign opcode    = r_opcode;
    assign rd        = r_rd;
    assign rs        = r_rs;
    assign k         = r_k;
    assign len       = r_len;

`ifdef DECODE_ILLEGAL_EN
    logic       r_illegal;
    logic [7:0] r_illegal_cnt;

    assign illegal     = r_illegal;
    assign illegal_cnt = r_illegal_cnt;

    // Counter survives flush; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal     <= 1'b0;
            r_illegal_cnt <= '0;
        end else if (!flush && in_valid) begin
            if (r_state == S_OP && !w_long) begin
                r_illegal <= w_illegal;
                if (w_illegal && r_illegal_cnt != 8'hFF)
                    r_illegal_cnt <= r_illegal_cnt + 8'd1;
            end else if (r_state == S_ARG) begin
                r_illegal <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_OP;
            r_byte0     <= '0;
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_rs        <= '0;
            r_k         <= '0;
            r_len       <= 1'b0;
        end else if (flush) begin
            r_state     <= S_OP;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_OP: begin
                    if (in_valid) begin
                        if (w_long) begin
                            r_byte0 <= in_byte;
                            r_state <= S_ARG;
                        end else begin
                            r_opcode    <= w_opc;
                            r_rd        <= in_byte[REG_W-1:0];
                            r_rs        <= '0;
                            r_k         <= '0;
                            r_len       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end
                    end
                end
                S_ARG: begin
                    if (in_valid) begin
                        r_opcode    <= r_byte0[DATA_W-1 -: OPC_W];
                        r_rd        <= r_byte0[REG_W-1:0];
                        r_rs        <= in_byte[DATA_W-1 -: REG_W];
                        r_k         <= in_byte;
                        r_len       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_OP;
                    end
                end
                default: r_state <= S_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode; expected bundles are queued when stimulus is driven.
module tb_instr_fetch_decode;

    typedef struct packed {
        logic [4:0] opc;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] k;
        logic       len;
        logic       ill;
    } bundle_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_byte = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] k;
    logic       len;
`ifdef DECODE_ILLEGAL_EN
    logic       illegal;
    logic [7:0] illegal_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bundle_t     exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_decode #(
        .DATA_W(8), .OPC_W(5), .REG_W(3), .LONG_OPC_MIN(16), .NUM_OPC(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .k(k), .len(len)
`ifdef DECODE_ILLEGAL_EN
        , .illegal(illegal), .illegal_cnt(illegal_cnt)
`endif
    );

    function automatic bundle_t mk(input logic [4:0] opc, input logic [2:0] r_d, input logic [2:0] r_s,
                                   input logic [7:0] kk, input logic ln, input logic il);
        bundle_t b;
        b.opc = opc; b.rd = r_d; b.rs = r_s; b.k = kk; b.len = ln; b.ill = il;
        return b;
    endfunction

    function automatic bundle_t get_obs();
        bundle_t b;
        b.opc = opcode; b.rd = rd; b.rs = rs; b.k = k; b.len = len;
`ifdef DECODE_ILLEGAL_EN
        b.ill = illegal;
`else
        b.ill = 1'b0;
`endif
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte and returns 1 time unit after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int unsigned t = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: byte %h never accepted (in_ready=%b)", b, in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bundle_t obs;
        rst_n = 1'b0;
        step();
        obs = get_obs();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== mk(0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL reset_state: got ov=%b ir=%b bundle=%h want ov=0 ir=1 bundle=%h",
                     out_valid, in_ready, obs, mk(0, 0, 0, 0, 0, 0));
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_short();
        bundle_t e, obs;
        out_ready = 1'b1;
        exp_q.push_back(mk(5'd5, 3'd3, 3'd0, 8'h00, 1'b0, 1'b0));
        send_byte(8'h2B);
        e = exp_q.pop_front();
        obs = get_obs();
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== e) begin
            n_bad++;
            $display("FAIL short_bundle: got ov=%b %h want ov=1 %h", out_valid, obs, e);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL short_drain: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_long();
        bundle_t e, obs;
        out_ready = 1'b1;
        exp_q.push_back(mk(5'd17, 3'd2, 3'd7, 8'hE5, 1'b1, 1'b0));
        send_byte(8'h8A);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL long_gap%0d: got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready);
            end
            step();
        end
        send_byte(8'hE5);
        e = exp_q.pop_front();
        obs = get_obs();
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== e) begin
            n_bad++;
            $display("FAIL long_bundle: got ov=%b %h want ov=1 %h", out_valid, obs, e);
        end
        step();
    endtask

    task automatic test_stall();
        bundle_t e, obs;
        out_ready = 1'b0;
        exp_q.push_back(mk(5'd5, 3'd3, 3'd0, 8'h00, 1'b0, 1'b0));
        send_byte(8'h2B);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            obs = get_obs();
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== e) begin
                n_bad++;
                $display("FAIL stall_hold%0d: got ov=%b ir=%b %h want ov=1 ir=0 %h",
                         i, out_valid, in_ready, obs, e);
            end
            step();
        end
        exp_q.push_back(mk(5'd2, 3'd1, 3'd0, 8'h00, 1'b0, 1'b0));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_byte   = 8'h11;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        e = exp_q.pop_front();
        obs = get_obs();
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== e) begin
            n_bad++;
            $display("FAIL stall_next: got ov=%b %h want ov=1 %h", out_valid, obs, e);
        end
        step();
    endtask

    task automatic test_flush();
        bundle_t e, obs;
        out_ready = 1'b1;
        send_byte(8'h8A);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h11;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL flush_quiet%0d: got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready);
            end
            step();
        end
        exp_q.push_back(mk(5'd2, 3'd1, 3'd0, 8'h00, 1'b0, 1'b0));
        send_byte(8'h11);
        e = exp_q.pop_front();
        obs = get_obs();
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== e) begin
            n_bad++;
            $display("FAIL flush_after: got ov=%b %h want ov=1 %h", out_valid, obs, e);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b0[12];
        logic [7:0]  b1[12];
        int unsigned got = 0;
        for (int i = 0; i < 12; i++) begin
            logic [4:0] opc;
            opc   = 5'($urandom_range(0, 23));
            b0[i] = {opc, 3'($urandom_range(0, 7))};
            b1[i] = 8'($urandom_range(0, 255));
            if (opc >= 5'd16)
                exp_q.push_back(mk(opc, b0[i][2:0], b1[i][7:5], b1[i], 1'b1, 1'b0));
            else
                exp_q.push_back(mk(opc, b0[i][2:0], 3'd0, 8'h00, 1'b0, 1'b0));
        end
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    send_byte(b0[i]);
                    if (b0[i][7:3] >= 5'd16) send_byte(b1[i]);
                end
            end
            begin
                bundle_t e, obs;
                for (int c = 0; c < 1000 && got < 12; c++) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    if (out_valid === 1'b1 && out_ready) begin
                        e = exp_q.pop_front();
                        obs = get_obs();
                        got++;
                        n_cmp++;
                        if (obs !== e) begin
                            n_bad++;
                            $display("FAIL b2b_bundle%0d: got %h want %h", got, obs, e);
                        end
                    end
                end
            end
        join
        n_cmp++;
        if (got != 12) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d bundles want 12", got);
        end
        out_ready = 1'b1;
        step();
        step();
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        bundle_t e, obs;
        out_ready = 1'b0;
        send_byte(8'h2B);
        #2;
        rst_n = 1'b0;
        #1;
        obs = get_obs();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== mk(0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL async_reset: got ov=%b ir=%b %h want ov=0 ir=1 %h",
                     out_valid, in_ready, obs, mk(0, 0, 0, 0, 0, 0));
        end
        #1;
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        exp_q.push_back(mk(5'd2, 3'd1, 3'd0, 8'h00, 1'b0, 1'b0));
        send_byte(8'h11);
        e = exp_q.pop_front();
        obs = get_obs();
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== e) begin
            n_bad++;
            $display("FAIL post_reset: got ov=%b %h want ov=1 %h", out_valid, obs, e);
        end
        step();
    endtask

`ifdef DECODE_ILLEGAL_EN
    task automatic test_illegal();
        bundle_t    e, obs;
        logic [7:0] want_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(mk(5'd24, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1));
            want_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            send_byte(8'hC0);
            e = exp_q.pop_front();
            obs = get_obs();
            n_cmp++;
            if (out_valid !== 1'b1 || obs !== e || illegal_cnt !== want_cnt) begin
                n_bad++;
                $display("FAIL illegal%0d: got ov=%b %h cnt=%0d want ov=1 %h cnt=%0d",
                         i, out_valid, obs, illegal_cnt, e, want_cnt);
            end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (illegal_cnt !== 8'd255 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_flush: got cnt=%0d ov=%b want cnt=255 ov=0", illegal_cnt, out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_short();
        test_long();
        test_stall();
        test_flush();
        test_back_to_back();
        test_async_reset();
`ifdef DECODE_ILLEGAL_EN
        test_illegal();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Sequential successor to the combinational instruction-field split.
- Accepts the instruction stream one byte per valid/ready transfer.
- Assembles one-byte (short) and two-byte (long) instructions and emits one registered decoded bundle (opcode, rd, rs, k, len) per instruction.
- Sits between program-memory fetch and the execute/register-file stage; the output register decouples fetch stalls from execute stalls.

Parameters:
- DATA_W, 8: instruction byte width.
- OPC_W, 5: opcode field width, taken from the byte-0 MSBs.
- REG_W, 3: register index width; OPC_W+REG_W must equal DATA_W.
- LONG_OPC_MIN, 16: opcodes >= this value are long and consume an operand byte.
- NUM_OPC, 24: opcodes >= this value are illegal (used only under DECODE_ILLEGAL_EN).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of the partial instruction and the output register.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  block accepts in_byte this cycle.
- in_byte  in  DATA_W  instruction byte.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- opcode  out  OPC_W  byte0[DATA_W-1 -: OPC_W].
- rd  out  REG_W  byte0[REG_W-1:0].
- rs  out  REG_W  byte1[DATA_W-1 -: REG_W]; 0 for short instructions.
- k  out  DATA_W  byte1; 0 for short instructions.
- len  out  1  0 = short, 1 = long.
- illegal  out  1  only under DECODE_ILLEGAL_EN.
- illegal_cnt  out  8  only under DECODE_ILLEGAL_EN.

Behaviour:
- Reset (rst_n low, asynchronous)
  - State = S_OP.
  - out_valid, opcode, rd, rs, k, len = 0.
  - The opcode-byte holding register = 0.
  - Reset mid-instruction discards the partial instruction.
- Transfer rule: a transfer occurs on a rising edge where valid && ready. Byte and bundle contents must be held stable while valid && !ready.
- in_ready = (state == S_OP) || (state == S_ARG). Combinational from state only; never depends on in_valid.
- FSM states: S_OP, S_ARG, S_OUT.
  - S_OP, byte accepted, opcode < LONG_OPC_MIN: load the output register with len=0, rs=0, k=0; set out_valid=1 next cycle; go to S_OUT.
  - S_OP, byte accepted, opcode >= LONG_OPC_MIN: store byte0; go to S_ARG.
  - S_ARG, byte accepted: load the output register with byte0 fields, rs and k from byte1, len=1; out_valid=1; go to S_OUT.
  - S_OUT: hold outputs. On out_valid && out_ready, clear out_valid and go to S_OP.
- Latency: bundle visible one cycle after the final byte is accepted.
- Maximum throughput: one short instruction per 2 cycles, one long instruction per 3 cycles.
- No bubble stuffing: while in_valid is low in S_OP or S_ARG, state holds.
- flush (priority over every transfer in the same cycle)
  - Next state = S_OP; out_valid = 0.
  - A byte presented that cycle is ignored, even though in_ready is high.
  - Field outputs keep their last values (don't-care while out_valid = 0).
- Simultaneous out_ready in S_OUT with in_valid: no byte is accepted that cycle (in_ready = 0). The next instruction starts the following cycle.
- Output fields change only on an output-register load, never while out_valid is high.

Optional Feature:
- DECODE_ILLEGAL_EN defined:
  - Output bit `illegal` is registered with the bundle; it equals opcode >= NUM_OPC.
  - An illegal opcode is always treated as short, regardless of LONG_OPC_MIN, and never consumes a second byte.
  - illegal_cnt is an 8-bit saturating count (stops at 255) of illegal bundles, incremented when the bundle is loaded.
  - rst_n clears illegal_cnt; flush does not.
- DECODE_ILLEGAL_EN undefined:
  - Ports `illegal` and `illegal_cnt` are absent.
  - All opcodes are decoded purely by LONG_OPC_MIN.

Test Plan:
- Short instruction: 0x2B with out_ready=1 → one cycle later out_valid=1, opcode=5, rd=3, rs=0, k=0x00, len=0; next cycle out_valid=0 and in_ready=1.
- Long instruction: 0x8A, then 0xE5 after 2 idle cycles → stays in S_ARG during the gap; then opcode=17, rd=2, rs=7, k=0xE5, len=1.
- Output stall: out_ready=0 for 5 cycles after a bundle → in_ready=0 and fields held constant for all 5 cycles; release → next byte accepted the cycle after the handshake.
- flush: assert flush in S_ARG after 0x8A, concurrent with byte 0x11 → no bundle; then 0x11 → opcode=2, rd=1, len=0.
- rst_n asserted asynchronously mid-S_OUT → out_valid drops immediately without a clock edge; first post-reset byte is decoded as an opcode byte.
- DECODE_ILLEGAL_EN: bytes 0xC0 (opcode 24) sent 300 times → every bundle has illegal=1 and len=0; illegal_cnt saturates at 255; flush leaves it at 255.
